// File: rtl/rmii_rx_deframe.sv
// RMII receive deframer: strips preamble and SFD from the PHY dibit stream and
// forwards a gap-free frame body to eth_rx, with saturating frame/error counters.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | waiting for the first 01 preamble dibit (00 dibits are ignored)
// PREAMBLE | counting 01 dibits, waiting for the 11 SFD
// BODY     | forwarding body dibits to eth_rx, checking length and alignment
// DISCARD  | dropping the rest of a bad or partial frame until carrier ends
module rmii_rx_deframe #(
    parameter int MIN_PREAMBLE_DIBITS = 8,
    parameter int MAX_FRAME_DIBITS    = 6088,
    parameter int STAT_WIDTH          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  crs_dv,
    input  logic [1:0]            rxd,
    output logic                  outclk,
    output logic [1:0]            out,
    output logic                  done,
    output logic                  err,
    output logic [STAT_WIDTH-1:0] frame_cnt,
    output logic [STAT_WIDTH-1:0] err_cnt
);

    localparam int PW = $clog2(MIN_PREAMBLE_DIBITS + 1);
    localparam int BW = $clog2(MAX_FRAME_DIBITS + 1);
    localparam logic [PW-1:0] PRE_LOAD  = PW'(MIN_PREAMBLE_DIBITS - 1);
    localparam logic [BW-1:0] BODY_LOAD = BW'(MAX_FRAME_DIBITS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        BODY     = 2'd2,
        DISCARD  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          d1_dv, d2_dv;
    logic [1:0]    d1_rxd, d2_rxd;
    logic          first_cyc;
    logic [PW-1:0] pre_left, pre_left_nxt;
    logic [BW-1:0] body_left, body_left_nxt;
    logic [1:0]    body_phase, body_phase_nxt;
    logic          valid;
    logic          eoc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_dv  <= 1'b0;
            d1_rxd <= 2'b00;
            d2_dv  <= 1'b0;
            d2_rxd <= 2'b00;
        end else begin
            d1_dv  <= crs_dv;
            d1_rxd <= rxd;
            d2_dv  <= d1_dv;
            d2_rxd <= d1_rxd;
        end
    end

    // A d2 dibit with dv low is still data if dv returns next cycle: PHYs
    // toggle CRS_DV at end of carrier while the FIFO drains.
    assign valid = d2_dv | d1_dv;
    assign eoc   = ~d1_dv & ~crs_dv;
    assign out   = d2_rxd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            first_cyc  <= 1'b1;
            pre_left   <= '0;
            body_left  <= '0;
            body_phase <= 2'd0;
        end else begin
            state      <= state_nxt;
            first_cyc  <= 1'b0;
            pre_left   <= pre_left_nxt;
            body_left  <= body_left_nxt;
            body_phase <= body_phase_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pre_left_nxt   = pre_left;
        body_left_nxt  = body_left;
        body_phase_nxt = body_phase;
        outclk         = 1'b0;
        done           = 1'b0;
        err            = 1'b0;

        if (first_cyc) begin
            // Released into live carrier: we joined mid-frame, so skip it.
            state_nxt = crs_dv ? DISCARD : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        case (d2_rxd)
                            2'b00: state_nxt = IDLE;
                            2'b01: begin
                                state_nxt    = PREAMBLE;
                                pre_left_nxt = PRE_LOAD;
                            end
                            default: begin
                                err       = 1'b1;
                                state_nxt = DISCARD;
                            end
                        endcase
                    end
                end

                PREAMBLE: begin
                    if (eoc) begin
                        err       = 1'b1;
                        state_nxt = DISCARD;
                    end else if (valid) begin
                        case (d2_rxd)
                            2'b01: begin
                                if (pre_left != '0) begin
                                    pre_left_nxt = pre_left - PW'(1);
                                end
                            end
                            2'b11: begin
                                if (pre_left == '0) begin
                                    state_nxt      = BODY;
                                    body_left_nxt  = BODY_LOAD;
                                    body_phase_nxt = 2'd0;
                                end else begin
                                    err       = 1'b1;
                                    state_nxt = DISCARD;
                                end
                            end
                            default: begin
                                err       = 1'b1;
                                state_nxt = DISCARD;
                            end
                        endcase
                    end
                end

                BODY: begin
                    if (valid) begin
                        outclk         = 1'b1;
                        body_left_nxt  = body_left - BW'(1);
                        body_phase_nxt = body_phase + 2'd1;
                        // End of carrier takes priority over the length limit.
                        if (eoc) begin
                            done      = (body_phase == 2'd3);
                            err       = (body_phase != 2'd3);
                            state_nxt = IDLE;
                        end else if (body_left == BW'(1)) begin
                            err       = 1'b1;
                            state_nxt = DISCARD;
                        end
                    end else if (eoc) begin
                        state_nxt = IDLE;
                    end
                end

                DISCARD: begin
                    if (eoc) begin
                        state_nxt = IDLE;
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (done && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + STAT_WIDTH'(1);
            end
            if (err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rmii_rx_deframe.sv
// Bench for rmii_rx_deframe: stimulus is built frame by frame, and the expected
// per-cycle outputs are derived from each frame's shape rather than from an FSM.
module tb_rmii_rx_deframe;

    localparam int MIN_P = 8;
    localparam int MAX_B = 6088;
    localparam int SW    = 3;
    localparam int NMAX  = 24000;
    localparam int SAT   = (1 << SW) - 1;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          crs_dv = 1'b0;
    logic [1:0]    rxd    = 2'b00;
    logic          outclk;
    logic [1:0]    out;
    logic          done;
    logic          err;
    logic [SW-1:0] frame_cnt;
    logic [SW-1:0] err_cnt;

    rmii_rx_deframe #(
        .MIN_PREAMBLE_DIBITS(MIN_P),
        .MAX_FRAME_DIBITS(MAX_B),
        .STAT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .crs_dv(crs_dv),
        .rxd(rxd),
        .outclk(outclk),
        .out(out),
        .done(done),
        .err(err),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt)
    );

    always #10 clk = ~clk;

    // Stimulus per pin cycle; expectations indexed by pin cycle + 2.
    bit       s_dv   [NMAX];
    bit [1:0] s_rxd  [NMAX];
    bit       e_oc   [NMAX + 4];
    bit [1:0] e_out  [NMAX + 4];
    bit       e_done [NMAX + 4];
    bit       e_err  [NMAX + 4];
    int       wr = 0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_fr = 0;
    int m_er = 0;
    int n_oc = 0;
    int n_done = 0;
    int first_oc = -1;
    int rst_at = -1;

    function automatic void chk(string nm, int act, int ex);
        checks++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, ex);
        end
    endfunction

    function automatic int sat(int x);
        return (x > SAT) ? SAT : x;
    endfunction

    function automatic void push(bit dv, bit [1:0] d);
        s_dv[wr]  = dv;
        s_rxd[wr] = d;
        wr++;
    endfunction

    function automatic void gap();
        int g;
        g = int'($urandom_range(3, 8));
        for (int i = 0; i < g; i++) push(1'b0, 2'b00);
    endfunction

    // z leading 00s, p preamble 01s, a terminating dibit, then b body dibits.
    // The frame is framed only if term is 11 after at least MIN_P 01s;
    // otherwise the error lands on the terminating dibit.
    function automatic void gen_frame(int z, int p, bit [1:0] term, int b, bit tog);
        int  t_idx;
        int  k_idx;
        bit  framed;
        bit  dv;
        for (int i = 0; i < z; i++) push(1'b1, 2'b00);
        for (int i = 0; i < p; i++) push(1'b1, 2'b01);
        t_idx = wr;
        push(1'b1, term);
        framed = (term == 2'b11) && (p >= MIN_P);
        if (!framed) e_err[t_idx + 2] = 1'b1;
        for (int k = 1; k <= b; k++) begin
            dv = 1'b1;
            if (tog && b >= 5 && k > b - 4) dv = (((b - k) % 2) == 0);
            k_idx = wr;
            push(dv, 2'($urandom_range(0, 3)));
            if (framed && k <= MAX_B) begin
                e_oc[k_idx + 2]  = 1'b1;
                e_out[k_idx + 2] = s_rxd[k_idx];
                if (k == MAX_B && b > MAX_B) e_err[k_idx + 2] = 1'b1;
                else if (k == b) begin
                    if (b % 4 == 0) e_done[k_idx + 2] = 1'b1;
                    else            e_err[k_idx + 2]  = 1'b1;
                end
            end
        end
        gap();
    endfunction

    function automatic void compare_cycle(int c);
        if (rst) begin
            m_fr = 0;
            m_er = 0;
        end else begin
            chk("outclk", int'(outclk), int'(e_oc[c]));
            chk("done", int'(done), int'(e_done[c]));
            chk("err", int'(err), int'(e_err[c]));
            if (e_oc[c]) chk("out", int'(out), int'(e_out[c]));
            chk("frame_cnt", int'(frame_cnt), sat(m_fr));
            chk("err_cnt", int'(err_cnt), sat(m_er));
            if (e_done[c]) m_fr++;
            if (e_err[c])  m_er++;
            if (outclk === 1'b1) begin
                if (n_oc == 0) first_oc = c;
                n_oc++;
            end
            if (done === 1'b1) n_done++;
        end
    endfunction

    task automatic drive(input int upto);
        while (cyc < upto) begin
            @(posedge clk);
            #2;
            crs_dv = s_dv[cyc];
            rxd    = s_rxd[cyc];
            if (cyc == rst_at) begin
                #3 rst = 1'b1;
                #1;
                chk("rst_outclk", int'(outclk), 0);
                chk("rst_out", int'(out), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_err", int'(err), 0);
                chk("rst_frame_cnt", int'(frame_cnt), 0);
                chk("rst_err_cnt", int'(err_cnt), 0);
            end
            if (cyc == rst_at + 2) #3 rst = 1'b0;
            @(negedge clk);
            compare_cycle(cyc);
            cyc++;
        end
    endtask

    int seg1, seg2, seg3, seg4, seg5, seg6, seg_rand, seg_sat, seg_rst;
    int z, ty, body0;

    initial begin
        gen_frame(0, 31, 2'b11, 256, 1'b0);           seg1 = wr;
        gen_frame(0, 31, 2'b11, 256, 1'b1);           seg2 = wr;
        gen_frame(0, 4, 2'b11, 20, 1'b0);
        gen_frame(0, MIN_P, 2'b11, 64, 1'b0);         seg3 = wr;
        gen_frame(0, 10, 2'b11, 257, 1'b0);           seg4 = wr;
        gen_frame(0, 10, 2'b11, MAX_B + 12, 1'b0);    seg5 = wr;
        gen_frame(0, 10, 2'b11, MAX_B, 1'b0);         seg6 = wr;
        for (int f = 0; f < 40; f++) begin
            z  = int'($urandom_range(0, 3));
            ty = int'($urandom_range(0, 4));
            case (ty)
                0: gen_frame(z, int'($urandom_range(MIN_P, 20)), 2'b11,
                             int'($urandom_range(1, 80)), bit'($urandom_range(0, 1)));
                1: gen_frame(z, int'($urandom_range(1, MIN_P - 1)), 2'b11,
                             int'($urandom_range(1, 20)), 1'b0);
                2: gen_frame(z, 0, 2'($urandom_range(2, 3)),
                             int'($urandom_range(1, 20)), 1'b0);
                3: gen_frame(z, int'($urandom_range(1, 15)),
                             ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10,
                             int'($urandom_range(1, 20)), 1'b0);
                default: begin
                    for (int i = 0; i < z + 1 + int'($urandom_range(0, 8)); i++) push(1'b1, 2'b00);
                    gap();
                end
            endcase
        end
        seg_rand = wr;
        for (int f = 0; f < 8; f++) gen_frame(0, 9, 2'b11, 16, 1'b0);
        for (int f = 0; f < 8; f++) gen_frame(0, 3, 2'b11, 8, 1'b0);
        seg_sat = wr;
        body0 = wr + 13;
        gen_frame(0, 12, 2'b11, 100, 1'b0);
        rst_at = body0 + 40;
        for (int i = rst_at; i < wr + 3; i++) begin
            e_oc[i]   = 1'b0;
            e_done[i] = 1'b0;
            e_err[i]  = 1'b0;
        end
        gen_frame(0, 10, 2'b11, 32, 1'b0);
        seg_rst = wr;

        repeat (2) @(negedge clk);
        chk("init_outclk", int'(outclk), 0);
        chk("init_out", int'(out), 0);
        chk("init_done", int'(done), 0);
        chk("init_err", int'(err), 0);
        chk("init_frame_cnt", int'(frame_cnt), 0);
        chk("init_err_cnt", int'(err_cnt), 0);
        @(posedge clk);
        #5 rst = 1'b0;

        drive(seg1);
        chk("t1_frame_cnt", int'(frame_cnt), 1);
        chk("t1_outclks", n_oc, 256);
        chk("t1_first_outclk", first_oc, 34);
        chk("t1_dones", n_done, 1);
        drive(seg2);
        chk("t2_frame_cnt", int'(frame_cnt), 2);
        chk("t2_outclks", n_oc, 512);
        drive(seg3);
        chk("t3_err_cnt", int'(err_cnt), 1);
        chk("t3_frame_cnt", int'(frame_cnt), 3);
        chk("t3_outclks", n_oc, 576);
        drive(seg4);
        chk("t4_err_cnt", int'(err_cnt), 2);
        chk("t4_outclks", n_oc, 833);
        drive(seg5);
        chk("t5_err_cnt", int'(err_cnt), 3);
        chk("t5_outclks", n_oc, 833 + MAX_B);
        drive(seg6);
        chk("t6_frame_cnt", int'(frame_cnt), 4);
        chk("t6_err_cnt", int'(err_cnt), 3);
        drive(seg_rand);
        drive(seg_sat);
        chk("sat_frame_cnt", int'(frame_cnt), 7);
        chk("sat_err_cnt", int'(err_cnt), 7);
        drive(seg_rst);
        chk("post_rst_frame_cnt", int'(frame_cnt), 1);
        chk("post_rst_err_cnt", int'(err_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
